db_controller: RTL and testbench
================================

Name: db_controller

Overview:
- Debug command controller between the UART serial driver and the MCU.
- Accepts one decoded command (cmd/addr/d_in) per out_valid pulse and sequences it against the MCU:
  - pause/resume/reset
  - register file and memory access, with automatic pause around each access
  - a hardware breakpoint table compared against the PC
- Returns a 32-bit result and a 2-bit error code, then drops busy so the driver can transmit the reply.

Parameters:
- NUM_BP, 8: breakpoint table entries (1..16).
- ACK_TIMEOUT, 1024: maximum cycles to wait for mcu_paused or mem_ack before aborting.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- valid  in  1  one-cycle command strobe from the serial driver
- cmd  in  4  command code
- addr  in  32  address / breakpoint PC / register index
- d_in  in  32  write data
- busy  out  1  command in progress
- d_rd  out  32  result data
- error  out  2  result code: 0 OK, 1 bad command/argument, 2 breakpoint full/not found, 3 timeout
- mcu_pause  out  1  pause request to the MCU
- mcu_reset  out  1  one-cycle MCU reset pulse
- mcu_paused  in  1  MCU has halted
- pc  in  32  current MCU PC
- mem_rd, mem_we  out  1  one-cycle memory strobes
- mem_size  out  2  0 = byte, 2 = word
- mem_addr, mem_wdata  out  32  memory address and write data
- mem_rdata  in  32  memory read data
- mem_ack  in  1  memory access complete
- rf_rd, rf_we  out  1  one-cycle register file strobes
- rf_addr  out  5  register index
- rf_wdata  out  32  register write data
- rf_rdata  in  32  register read data, valid 1 cycle after rf_rd

Behaviour:
- Reset (reset = 0 at a clk edge):
  - All outputs become 0.
  - Breakpoint table valid bits, pause_req, bp_hit, acc_pause and the timer are cleared.
  - Reset mid-command aborts the command with no reply.
- Command codes:
  - 0x1 PAUSE, 0x2 RESUME, 0x3 MCU_RESET, 0x4 STATUS
  - 0x5 BP_ADD, 0x6 BP_RM, 0x7 BP_CLR
  - 0x8 RF_RD, 0x9 RF_WR
  - 0xA MEM_RD_WORD, 0xB MEM_RD_BYTE, 0xC MEM_WR_WORD, 0xD MEM_WR_BYTE
  - Any other code: error = 1, d_rd = 0.
- Acceptance and reply:
  - valid is sampled only in S_IDLE. busy goes high on the same edge (registered, high the cycle after valid).
  - valid while busy is ignored.
  - d_rd and error update on the edge where busy falls and hold until the next accepted command.
- mcu_pause = pause_req | acc_pause.
- States: S_IDLE, S_PAUSE_WAIT, S_ACCESS, S_ACK_WAIT, S_RF_CAP, S_RESTORE, S_DONE.
- S_DONE lasts one cycle, then S_IDLE.
- Command behaviour:
  - PAUSE: set pause_req, go to S_PAUSE_WAIT until mcu_paused, then S_DONE.
  - RESUME: clear pause_req and bp_hit, latch resume_pc = pc, disarm breakpoints, go to S_DONE.
  - MCU_RESET: mcu_reset pulses exactly 1 cycle; pause state is unchanged; go to S_DONE.
  - STATUS: d_rd = {29'b0, bp_hit, mcu_paused, pause_req}, 2-cycle busy.
  - BP_ADD:
    - If addr is already present: OK, no duplicate entry.
    - Else if a free slot exists: write the lowest free slot.
    - Else: error = 2.
  - BP_RM: invalidate the matching entry; if none matches, error = 2.
  - BP_CLR: invalidate all entries.
  - RF/MEM commands:
    - RF commands with addr[31:5] != 0: error = 1 immediately, no pause.
    - Otherwise set acc_pause, wait for mcu_paused (S_PAUSE_WAIT), then issue a single strobe (S_ACCESS).
    - RF_RD: capture rf_rdata the next cycle (S_RF_CAP).
    - RF_WR: complete after the strobe.
    - MEM: wait for mem_ack (S_ACK_WAIT); reads capture mem_rdata.
    - MEM_RD_BYTE returns {24'b0, mem_rdata[7:0]}.
    - S_RESTORE: clear acc_pause; pause_req is untouched, so a user pause persists.
- Timeout:
  - The timer counts in S_PAUSE_WAIT and S_ACK_WAIT and resets on entry.
  - When the timer reaches ACK_TIMEOUT: error = 3, d_rd = 0, go to S_RESTORE (PAUSE command: pause_req stays set).
- Breakpoints:
  - When mcu_pause = 0, armed = 1, and a valid entry equals pc: set pause_req and bp_hit on the next edge.
  - armed is set whenever pc != resume_pc.
  - A breakpoint hit on the same edge a command is accepted: both take effect; pause_req is simply set.
  - The breakpoint table is not modified by MCU_RESET.
- Back-to-back MEM_WR_WORD commands (program stream, spacing ≥ 1 UART word) must all complete; each is a fully independent pause/write/restore.

Test Plan:
- Reset low 2 cycles with valid = 1 → all outputs 0, busy stays 0. PAUSE then resume with no breakpoints → mcu_pause rises the cycle after valid and falls the cycle after RESUME is accepted.
- MEM_WR_WORD addr = 0x100, d_in = 0xDEADBEEF; mcu_paused 3 cycles after pause, mem_ack 2 cycles after mem_we:
  - mem_we is a single cycle with mem_size = 2.
  - Then MEM_RD_WORD addr = 0x100 returns d_rd = 0xDEADBEEF, error = 0.
  - mcu_pause is low afterwards.
- Add NUM_BP breakpoints 0x0, 0x4, …, then one more → error = 2. Drive pc = 0x8 while running → pause_req and bp_hit = 1. STATUS returns 0x7. RESUME with pc held at 0x8 → no re-hit until pc changes to 0xC and back.
- mcu_paused held low → after ACK_TIMEOUT cycles error = 3, d_rd = 0, busy falls, mcu_pause released.
- RF_RD addr = 0x20 → error = 1, no rf_rd strobe. RF_WR addr = 5, d_in = 0x1234 then RF_RD addr = 5 → d_rd = 0x1234. cmd = 0xE → error = 1.
- valid pulsed again while busy → ignored. Assert reset mid MEM write → busy = 0 and mcu_pause = 0 next cycle.

Source files
------------

// File: rtl/db_controller.sv
// Debug command controller between the UART serial driver and the MCU: pause,
// resume, reset, auto-paused register/memory access and a PC breakpoint table.
module db_controller #(
  parameter int NUM_BP      = 8,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [3:0]  cmd,
  input  logic [31:0] addr,
  input  logic [31:0] d_in,
  output logic        busy,
  output logic [31:0] d_rd,
  output logic [1:0]  error,
  output logic        mcu_pause,
  output logic        mcu_reset,
  input  logic        mcu_paused,
  input  logic [31:0] pc,
  output logic        mem_rd,
  output logic        mem_we,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        rf_rd,
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_wdata,
  input  logic [31:0] rf_rdata,
  output logic [2:0]  dbg_state
);

  // Handshake: valid is a one-cycle strobe taken only while busy is low; busy rises
  // on the accepting edge and falls on the edge that loads d_rd/error, which then
  // hold until the next accepted command.
  typedef enum logic [2:0] {
    S_IDLE, S_PAUSE_WAIT, S_ACCESS, S_ACK_WAIT, S_RF_CAP, S_RESTORE, S_DONE
  } state_t;

  localparam logic [3:0] C_PAUSE = 4'h1, C_RESUME = 4'h2, C_MCU_RESET = 4'h3,
                         C_STATUS = 4'h4, C_BP_ADD = 4'h5, C_BP_RM = 4'h6,
                         C_BP_CLR = 4'h7, C_RF_RD = 4'h8, C_RF_WR = 4'h9,
                         C_MEM_RD_W = 4'hA, C_MEM_RD_B = 4'hB,
                         C_MEM_WR_W = 4'hC, C_MEM_WR_B = 4'hD;
  localparam logic [1:0] E_OK = 2'd0, E_CMD = 2'd1, E_BP = 2'd2, E_TIMEOUT = 2'd3;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  state_t              state_q, state_d;
  logic [3:0]          cmd_q, cmd_d;
  logic [31:0]         addr_q, addr_d, din_q, din_d;
  logic [31:0]         res_q, res_d, d_rd_q, d_rd_d, resume_pc_q, resume_pc_d;
  logic [1:0]          res_err_q, res_err_d, error_q, error_d;
  logic                busy_q, busy_d, pause_req_q, pause_req_d, bp_hit_q, bp_hit_d;
  logic                acc_pause_q, acc_pause_d, armed_q, armed_d;
  logic                mcu_reset_q, mcu_reset_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [NUM_BP-1:0]   bp_valid_q, bp_valid_d;
  logic [31:0]         bp_pc_q [NUM_BP];
  logic [31:0]         bp_pc_d [NUM_BP];
  logic [NUM_BP-1:0]   pc_match, addr_match, add_sel;
  logic                found_free, bp_fire, is_mem, is_read, is_byte, timer_done;

  assign is_mem     = (cmd_q >= C_MEM_RD_W) && (cmd_q <= C_MEM_WR_B);
  assign is_read    = (cmd_q == C_MEM_RD_W) || (cmd_q == C_MEM_RD_B);
  assign is_byte    = (cmd_q == C_MEM_RD_B) || (cmd_q == C_MEM_WR_B);
  assign timer_done = (timer_q == TW'(ACK_TIMEOUT));

  always_comb begin
    pc_match   = '0;
    addr_match = '0;
    add_sel    = '0;
    found_free = 1'b0;
    for (int i = 0; i < NUM_BP; i++) begin
      pc_match[i]   = bp_valid_q[i] && (bp_pc_q[i] == pc);
      addr_match[i] = bp_valid_q[i] && (bp_pc_q[i] == addr);
      if (!found_free && !bp_valid_q[i]) begin
        add_sel[i] = 1'b1;
        found_free = 1'b1;
      end
    end
  end

  assign bp_fire = !mcu_pause && armed_q && (|pc_match);

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    din_d       = din_q;
    res_d       = res_q;
    res_err_d   = res_err_q;
    d_rd_d      = d_rd_q;
    error_d     = error_q;
    busy_d      = busy_q;
    pause_req_d = pause_req_q;
    bp_hit_d    = bp_hit_q;
    acc_pause_d = acc_pause_q;
    timer_d     = timer_q;
    resume_pc_d = resume_pc_q;
    armed_d     = armed_q;
    mcu_reset_d = 1'b0;
    bp_valid_d  = bp_valid_q;
    bp_pc_d     = bp_pc_q;
    if (pc != resume_pc_q) armed_d = 1'b1;

    case (state_q)
      S_IDLE: if (valid) begin
        cmd_d     = cmd;
        addr_d    = addr;
        din_d     = d_in;
        busy_d    = 1'b1;
        res_d     = '0;
        res_err_d = E_OK;
        // Immediate commands pass through S_RESTORE so every reply has two busy cycles.
        state_d   = S_RESTORE;
        case (cmd)
          C_PAUSE: begin
            pause_req_d = 1'b1;
            timer_d     = '0;
            state_d     = S_PAUSE_WAIT;
          end
          C_RESUME: begin
            pause_req_d = 1'b0;
            bp_hit_d    = 1'b0;
            resume_pc_d = pc;
            armed_d     = 1'b0;
          end
          C_MCU_RESET: mcu_reset_d = 1'b1;
          C_STATUS:    res_d = {29'b0, bp_hit_q, mcu_paused, pause_req_q};
          C_BP_ADD: if (~|addr_match) begin
            if (found_free) begin
              bp_valid_d = bp_valid_q | add_sel;
              for (int i = 0; i < NUM_BP; i++) if (add_sel[i]) bp_pc_d[i] = addr;
            end else begin
              res_err_d = E_BP;
            end
          end
          C_BP_RM: if (|addr_match) bp_valid_d = bp_valid_q & ~addr_match;
                   else res_err_d = E_BP;
          C_BP_CLR: bp_valid_d = '0;
          C_RF_RD, C_RF_WR: if (addr[31:5] != 27'd0) begin
            res_err_d = E_CMD;
          end else begin
            acc_pause_d = 1'b1;
            timer_d     = '0;
            state_d     = S_PAUSE_WAIT;
          end
          C_MEM_RD_W, C_MEM_RD_B, C_MEM_WR_W, C_MEM_WR_B: begin
            acc_pause_d = 1'b1;
            timer_d     = '0;
            state_d     = S_PAUSE_WAIT;
          end
          default: res_err_d = E_CMD;
        endcase
      end
      S_PAUSE_WAIT: begin
        if (mcu_paused) begin
          state_d = (cmd_q == C_PAUSE) ? S_DONE : S_ACCESS;
        end else if (timer_done) begin
          res_d     = '0;
          res_err_d = E_TIMEOUT;
          state_d   = S_RESTORE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_ACCESS: begin
        if (cmd_q == C_RF_RD)      state_d = S_RF_CAP;
        else if (cmd_q == C_RF_WR) state_d = S_RESTORE;
        else begin
          timer_d = '0;
          state_d = S_ACK_WAIT;
        end
      end
      S_ACK_WAIT: begin
        if (mem_ack) begin
          if (is_read) res_d = is_byte ? {24'b0, mem_rdata[7:0]} : mem_rdata;
          state_d = S_RESTORE;
        end else if (timer_done) begin
          res_d     = '0;
          res_err_d = E_TIMEOUT;
          state_d   = S_RESTORE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RF_CAP: begin
        res_d   = rf_rdata;
        state_d = S_RESTORE;
      end
      S_RESTORE: begin
        acc_pause_d = 1'b0;
        state_d     = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        d_rd_d  = res_q;
        error_d = res_err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A hit wins over a RESUME accepted on the same edge.
    if (bp_fire) begin
      pause_req_d = 1'b1;
      bp_hit_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      res_q       <= '0;
      res_err_q   <= '0;
      d_rd_q      <= '0;
      error_q     <= '0;
      busy_q      <= 1'b0;
      pause_req_q <= 1'b0;
      bp_hit_q    <= 1'b0;
      acc_pause_q <= 1'b0;
      timer_q     <= '0;
      resume_pc_q <= '0;
      armed_q     <= 1'b0;
      mcu_reset_q <= 1'b0;
      bp_valid_q  <= '0;
      for (int i = 0; i < NUM_BP; i++) bp_pc_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      res_q       <= res_d;
      res_err_q   <= res_err_d;
      d_rd_q      <= d_rd_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
      pause_req_q <= pause_req_d;
      bp_hit_q    <= bp_hit_d;
      acc_pause_q <= acc_pause_d;
      timer_q     <= timer_d;
      resume_pc_q <= resume_pc_d;
      armed_q     <= armed_d;
      mcu_reset_q <= mcu_reset_d;
      bp_valid_q  <= bp_valid_d;
      for (int i = 0; i < NUM_BP; i++) bp_pc_q[i] <= bp_pc_d[i];
    end
  end

  assign busy      = busy_q;
  assign d_rd      = d_rd_q;
  assign error     = error_q;
  assign mcu_pause = pause_req_q | acc_pause_q;
  assign mcu_reset = mcu_reset_q;
  assign mem_rd    = (state_q == S_ACCESS) && is_mem && is_read;
  assign mem_we    = (state_q == S_ACCESS) && is_mem && !is_read;
  assign mem_size  = (is_mem && !is_byte) ? 2'd2 : 2'd0;
  assign mem_addr  = addr_q;
  assign mem_wdata = din_q;
  assign rf_rd     = (state_q == S_ACCESS) && (cmd_q == C_RF_RD);
  assign rf_we     = (state_q == S_ACCESS) && (cmd_q == C_RF_WR);
  assign rf_addr   = addr_q[4:0];
  assign rf_wdata  = din_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_db_controller.sv
// Directed bench for db_controller with a small MCU/memory/register-file model
// and hand-computed replies.
module tb_db_controller;
  localparam int NUM_BP = 8;
  localparam int ACK_TO = 40;
  localparam logic [3:0] C_PAUSE = 4'h1, C_RESUME = 4'h2, C_MCU_RESET = 4'h3,
                         C_STATUS = 4'h4, C_BP_ADD = 4'h5, C_BP_RM = 4'h6,
                         C_BP_CLR = 4'h7, C_RF_RD = 4'h8, C_RF_WR = 4'h9,
                         C_MEM_RD_W = 4'hA, C_MEM_RD_B = 4'hB,
                         C_MEM_WR_W = 4'hC, C_MEM_WR_B = 4'hD;

  logic        clk = 1'b0;
  logic        reset, valid;
  logic [3:0]  cmd;
  logic [31:0] addr, d_in, pc;
  logic        busy, mcu_pause, mcu_reset, mem_rd, mem_we, rf_rd, rf_we;
  logic [31:0] d_rd, mem_addr, mem_wdata, rf_wdata;
  logic [1:0]  error, mem_size;
  logic [4:0]  rf_addr;
  logic [2:0]  state_dbg;
  logic        mcu_paused = 1'b0;
  logic        mem_ack    = 1'b0;
  logic        ack_d1     = 1'b0;
  logic [31:0] mem_rdata  = '0;
  logic [31:0] rf_rdata   = '0;
  logic        stall_pause = 1'b0;
  int          pause_cnt = 0;
  int          we_cnt = 0, rf_rd_cnt = 0, rst_cnt = 0;
  logic [1:0]  last_size = '0;
  logic [31:0] last_we_addr = '0;
  logic [31:0] mem [256];
  logic [31:0] rf [32];
  int          n_cmp = 0, n_err = 0;

  db_controller #(.NUM_BP(NUM_BP), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk(clk), .reset(reset), .valid(valid), .cmd(cmd), .addr(addr), .d_in(d_in),
    .busy(busy), .d_rd(d_rd), .error(error), .mcu_pause(mcu_pause),
    .mcu_reset(mcu_reset), .mcu_paused(mcu_paused), .pc(pc), .mem_rd(mem_rd),
    .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .rf_rd(rf_rd), .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .rf_rdata(rf_rdata), .dbg_state(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // MCU halts 3 cycles after a pause request; memory acks 2 cycles after a strobe
  always @(posedge clk) begin
    if (!mcu_pause || stall_pause) begin
      pause_cnt  <= 0;
      mcu_paused <= 1'b0;
    end else if (pause_cnt == 2) begin
      mcu_paused <= 1'b1;
    end else begin
      pause_cnt <= pause_cnt + 1;
    end
    ack_d1  <= mem_rd | mem_we;
    mem_ack <= ack_d1;
    if (mem_we) begin
      we_cnt       <= we_cnt + 1;
      last_size    <= mem_size;
      last_we_addr <= mem_addr;
      if (mem_size == 2'd2) mem[mem_addr[9:2]] <= mem_wdata;
      else mem[mem_addr[9:2]] <= (mem[mem_addr[9:2]] & ~(32'hFF << {mem_addr[1:0], 3'b000}))
                                 | ({24'b0, mem_wdata[7:0]} << {mem_addr[1:0], 3'b000});
    end
    if (mem_rd) mem_rdata <= mem[mem_addr[9:2]] >> ((mem_size == 2'd2) ? 5'd0 : {mem_addr[1:0], 3'b000});
    if (rf_we) rf[rf_addr] <= rf_wdata;
    if (rf_rd) begin
      rf_rd_cnt <= rf_rd_cnt + 1;
      rf_rdata  <= rf[rf_addr];
    end
    if (mcu_reset) rst_cnt <= rst_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    valid = 1'b1; cmd = c; addr = a; d_in = d;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int cycles);
    cycles = 0;
    while (busy && cycles < 300) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, "_done"}, 32'(busy), 32'd0);
  endtask

  task automatic run(input string tag, input logic [3:0] c, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] exp_d, input logic [1:0] exp_e);
    int n;
    issue(c, a, d);
    wait_done(tag, n);
    check({tag, "_d"}, d_rd, exp_d);
    check({tag, "_err"}, 32'(error), 32'(exp_e));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n, w0, r0, s0;
    reset = 1'b0; valid = 1'b1; cmd = C_PAUSE; addr = '0; d_in = '0; pc = 32'h1000;
    repeat (2) begin
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
    end
    check("rst_d_rd", d_rd, 32'd0);
    check("rst_ctl", {19'b0, error, mcu_pause, mcu_reset, mem_rd, mem_we, mem_size,
                      rf_rd, rf_we, state_dbg}, 32'd0);
    check("rst_bus", mem_addr | mem_wdata | rf_wdata | {27'b0, rf_addr}, 32'd0);
    @(negedge clk);
    reset = 1'b1; valid = 1'b0;

    // PAUSE / RESUME edge timing
    @(negedge clk);
    valid = 1'b1; cmd = C_PAUSE;
    check("pause_pre", 32'(mcu_pause), 32'd0);
    @(negedge clk);
    valid = 1'b0;
    check("pause_rise", 32'(mcu_pause), 32'd1);
    check("pause_busy", 32'(busy), 32'd1);
    wait_done("pause", n);
    check("pause_err", 32'(error), 32'd0);
    @(negedge clk);
    valid = 1'b1; cmd = C_RESUME;
    check("resume_pre", 32'(mcu_pause), 32'd1);
    @(negedge clk);
    valid = 1'b0;
    check("resume_fall", 32'(mcu_pause), 32'd0);
    wait_done("resume", n);

    // memory write / read, word and byte
    w0 = we_cnt;
    run("memwr", C_MEM_WR_W, 32'h100, 32'hDEADBEEF, 32'd0, 2'd0);
    check("memwr_cnt", 32'(we_cnt - w0), 32'd1);
    check("memwr_size", 32'(last_size), 32'd2);
    check("memwr_unpause", 32'(mcu_pause), 32'd0);
    run("memrd", C_MEM_RD_W, 32'h100, 32'd0, 32'hDEADBEEF, 2'd0);
    check("memrd_unpause", 32'(mcu_pause), 32'd0);
    run("memwrb", C_MEM_WR_B, 32'h101, 32'h000000A5, 32'd0, 2'd0);
    check("memwrb_size", 32'(last_size), 32'd0);
    run("memrdb", C_MEM_RD_B, 32'h101, 32'd0, 32'h000000A5, 2'd0);
    run("memrd2", C_MEM_RD_W, 32'h100, 32'd0, 32'hDEADA5EF, 2'd0);

    // breakpoint table
    pc = 32'h2000;
    for (int i = 0; i < NUM_BP; i++) run("bpadd", C_BP_ADD, 32'(i * 4), 32'd0, 32'd0, 2'd0);
    run("bpdup", C_BP_ADD, 32'h8, 32'd0, 32'd0, 2'd0);
    run("bpfull", C_BP_ADD, 32'h40, 32'd0, 32'd0, 2'd2);
    run("bprm_miss", C_BP_RM, 32'h44, 32'd0, 32'd0, 2'd2);
    run("bprm", C_BP_RM, 32'h1C, 32'd0, 32'd0, 2'd0);
    run("bpadd_reuse", C_BP_ADD, 32'h40, 32'd0, 32'd0, 2'd0);
    run("bpfull2", C_BP_ADD, 32'h1C, 32'd0, 32'd0, 2'd2);
    check("bp_idle", 32'(mcu_pause), 32'd0);
    @(negedge clk);
    pc = 32'h8;
    @(negedge clk);
    check("bp_hit", 32'(mcu_pause), 32'd1);
    repeat (6) @(negedge clk);
    run("status_hit", C_STATUS, 32'd0, 32'd0, 32'h7, 2'd0);
    run("bp_resume", C_RESUME, 32'd0, 32'd0, 32'd0, 2'd0);
    repeat (4) @(negedge clk);
    check("bp_norehit", 32'(mcu_pause), 32'd0);
    run("status_clr", C_STATUS, 32'd0, 32'd0, 32'h0, 2'd0);
    @(negedge clk);
    pc = 32'hC;
    @(negedge clk);
    pc = 32'h8;
    check("bp_armwait", 32'(mcu_pause), 32'd0);
    @(negedge clk);
    check("bp_rehit", 32'(mcu_pause), 32'd1);
    run("bp_resume2", C_RESUME, 32'd0, 32'd0, 32'd0, 2'd0);
    pc = 32'h2000;
    run("bpclr", C_BP_CLR, 32'd0, 32'd0, 32'd0, 2'd0);
    run("bprm_empty", C_BP_RM, 32'h8, 32'd0, 32'd0, 2'd2);

    // timeout while the MCU never halts
    run("pre_to", C_MEM_RD_W, 32'h100, 32'd0, 32'hDEADA5EF, 2'd0);
    stall_pause = 1'b1;
    issue(C_MEM_RD_W, 32'h100, 32'd0);
    wait_done("timeout", n);
    check("to_len_min", 32'(n >= ACK_TO), 32'd1);
    check("to_len_max", 32'(n <= ACK_TO + 8), 32'd1);
    check("to_err", 32'(error), 32'd3);
    check("to_d_rd", d_rd, 32'd0);
    check("to_unpause", 32'(mcu_pause), 32'd0);
    stall_pause = 1'b0;

    // register file access and bad commands
    r0 = rf_rd_cnt;
    run("rf_badidx", C_RF_RD, 32'h20, 32'd0, 32'd0, 2'd1);
    check("rf_badidx_nostrobe", 32'(rf_rd_cnt - r0), 32'd0);
    check("rf_badidx_nopause", 32'(mcu_pause), 32'd0);
    run("rf_wr", C_RF_WR, 32'd5, 32'h1234, 32'd0, 2'd0);
    run("rf_rd", C_RF_RD, 32'd5, 32'd0, 32'h1234, 2'd0);
    run("bad_cmd_e", 4'hE, 32'd0, 32'd0, 32'd0, 2'd1);
    run("bad_cmd_0", 4'h0, 32'd0, 32'd0, 32'd0, 2'd1);

    // MCU reset keeps pause state
    run("pause2", C_PAUSE, 32'd0, 32'd0, 32'd0, 2'd0);
    s0 = rst_cnt;
    run("mcurst", C_MCU_RESET, 32'd0, 32'd0, 32'd0, 2'd0);
    check("mcurst_pulse", 32'(rst_cnt - s0), 32'd1);
    check("mcurst_pause", 32'(mcu_pause), 32'd1);
    run("resume3", C_RESUME, 32'd0, 32'd0, 32'd0, 2'd0);

    // valid while busy is ignored
    w0 = we_cnt;
    issue(C_MEM_WR_W, 32'h200, 32'h11111111);
    valid = 1'b1; cmd = C_MEM_WR_W; addr = 32'h204; d_in = 32'h22222222;
    @(negedge clk);
    valid = 1'b0;
    wait_done("busy_ign", n);
    repeat (3) @(negedge clk);
    check("busy_ign_cnt", 32'(we_cnt - w0), 32'd1);
    check("busy_ign_addr", last_we_addr, 32'h200);

    // back-to-back program stream
    for (int i = 0; i < 3; i++) run("stream_wr", C_MEM_WR_W, 32'(32'h300 + i * 4), 32'(32'hA0 + i), 32'd0, 2'd0);
    for (int i = 0; i < 3; i++) run("stream_rd", C_MEM_RD_W, 32'(32'h300 + i * 4), 32'd0, 32'(32'hA0 + i), 2'd0);

    // reset in the middle of a memory write
    w0 = we_cnt;
    issue(C_MEM_WR_W, 32'h380, 32'h55AA55AA);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_pause", 32'(mcu_pause), 32'd0);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check("rstmid_nowe", 32'(we_cnt - w0), 32'd0);
    run("rstmid_status", C_STATUS, 32'd0, 32'd0, 32'd0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
